irq_conditioner: RTL and testbench

- Sits directly upstream of the PIC and drives its 8-bit IRQ bus.
- Conditions raw external interrupt lines before priority encoding:
  - synchronises each line into clk,
  - optionally glitch-filters each line,
  - handles per-line level or rising-edge latching,
  - applies a per-line mask,
  - clears latched edge requests on a CPU acknowledge.
- Edge-mode requests that arrive while the line is already pending set a sticky overflow flag.

---
 rtl/irq_conditioner.sv | 140 ++++++++++++++
 tb/tb_irq_conditioner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_conditioner.sv
// irq_conditioner
//   Conditions raw external interrupt lines before they reach the PIC IRQ bus.
//   Each line is synchronised into clk, optionally glitch-filtered, and then
//   either followed as a level or latched on a rising edge. Latched edge
//   requests clear on a CPU acknowledge. A second edge on an already pending
//   line raises a sticky overflow flag.
//
//   Optional build macro: IRQ_GLITCH_FILTER_EN
//     defined   -> per-line filter; a new level is accepted only after
//                  FILTER_LEN consecutive differing synchronised samples
//     undefined -> accepted level is the synchroniser output
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   irq_raw   asynchronous request lines
//   irq_mask  1 = line enabled to the PIC
//   irq_edge  1 = rising-edge latched, 0 = level
//   ack       single-cycle acknowledge
//   ack_num   index of the acknowledged line
//   irq_out   pending & irq_mask
//   irq_ovf   sticky per-line overflow flag
module irq_conditioner #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  localparam int AW         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_raw,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic [N_IRQ-1:0] irq_edge,
  input  logic             ack,
  input  logic [AW-1:0]    ack_num,
  output logic [N_IRQ-1:0] irq_out,
  output logic [N_IRQ-1:0] irq_ovf
);

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] sync;
  logic [N_IRQ-1:0] acc;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] ovf_q, ovf_d;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= irq_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef IRQ_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [N_IRQ-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_IRQ-1:0]         acc_q, acc_d;

  // The counter tracks how many consecutive samples have disagreed with the
  // accepted level; the sample that brings the run to FILTER_LEN flips acc.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (sync[i] == acc_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
        cnt_d[i] = '0;
        acc_d[i] = sync[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
`else
  assign acc = sync;
`endif

  assign rise = acc & ~prev_q;

  // An acknowledge only acts on an edge-mode line that is actually pending.
  // Out-of-range ack_num values never match any line index.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = ack && (ack_num == AW'(i)) && irq_edge[i] && pending_q[i];
    end
  end

  // Set beats clear on pending, so an edge coinciding with its own ack is kept.
  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_edge[i]) begin
        pending_d[i] = rise[i] | (pending_q[i] & ~clr[i]);
        ovf_d[i]     = ~clr[i] & (ovf_q[i] | (rise[i] & pending_q[i]));
      end else begin
        pending_d[i] = acc[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      prev_q    <= acc;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign irq_out = pending_q & irq_mask;
  assign irq_ovf = ovf_q;

endmodule

// File: tb/tb_irq_conditioner.sv
module tb_irq_conditioner;

  localparam int N = 8;
  localparam int S = 2;
  localparam int F = 3;
`ifdef IRQ_GLITCH_FILTER_EN
  localparam int LAT = S + F;
  localparam int PL  = F;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT = S;
  localparam int PL  = 1;
  localparam bit FILT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq_raw = '0;
  logic [N-1:0] irq_mask = '0;
  logic [N-1:0] irq_edge = '0;
  logic         ack = 1'b0;
  logic [2:0]   ack_num = '0;
  logic [N-1:0] irq_out;
  logic [N-1:0] irq_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irq_conditioner #(.N_IRQ(N), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_raw  (irq_raw),
    .irq_mask (irq_mask),
    .irq_edge (irq_edge),
    .ack      (ack),
    .ack_num  (ack_num),
    .irq_out  (irq_out),
    .irq_ovf  (irq_ovf)
  );

  // Reference model: requests and overflow tracked per line from the rules.
  logic [N-1:0] m_pend, m_ovf, m_acc, m_prev;
  logic [N-1:0] raw_h[$];
  logic [N-1:0] sync_h[$];

  function automatic void model_reset();
    m_pend = '0;
    m_ovf  = '0;
    m_acc  = '0;
    m_prev = '0;
    raw_h.delete();
    sync_h.delete();
    for (int j = 0; j < S; j++) raw_h.push_back('0);
    for (int j = 0; j < F; j++) sync_h.push_back('0);
  endfunction

  function automatic void model_edge();
    logic [N-1:0] sync_now, acc_cur, nxt_acc, rise;
    bit all_diff;
    bit ackd;
    sync_now = raw_h[S-1];          // raw as sampled S edges ago
    raw_h.push_front(irq_raw);
    void'(raw_h.pop_back());
`ifdef IRQ_GLITCH_FILTER_EN
    acc_cur = m_acc;
    sync_h.push_front(sync_now);
    void'(sync_h.pop_back());
    nxt_acc = m_acc;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < F; j++) if (sync_h[j][i] == m_acc[i]) all_diff = 1'b0;
      if (all_diff) nxt_acc[i] = ~m_acc[i];
    end
`else
    acc_cur = sync_now;
    nxt_acc = sync_now;
`endif
    rise = acc_cur & ~m_prev;
    for (int i = 0; i < N; i++) begin
      if (!irq_edge[i]) begin
        m_pend[i] = acc_cur[i];
      end else begin
        ackd = ack && (int'(ack_num) == i) && m_pend[i];
        if (rise[i]) begin
          if (m_pend[i] && !ackd) m_ovf[i] = 1'b1;
          else if (ackd) m_ovf[i] = 1'b0;
          m_pend[i] = 1'b1;
        end else if (ackd) begin
          m_pend[i] = 1'b0;
          m_ovf[i]  = 1'b0;
        end
      end
    end
    m_prev = acc_cur;
    m_acc  = nxt_acc;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] lines, input int len);
    irq_raw = irq_raw | lines;
    repeat (len) step();
    irq_raw = irq_raw & ~lines;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    irq_raw = 8'hFF;
    irq_mask = 8'hFF;
    irq_edge = 8'h00;
    model_reset();
    repeat (3) step();
    n_checks++;
    if (irq_out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h expected 00", irq_out); end
    n_checks++;
    if (irq_ovf !== 8'h00) begin n_fail++; $display("FAIL reset_ovf: got %h expected 00", irq_ovf); end
    rst = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      n_checks++;
      if (irq_out !== ((c <= LAT) ? 8'h00 : 8'hFF)) begin
        n_fail++;
        $display("FAIL release_latency c=%0d: got %h expected %h", c, irq_out, (c <= LAT) ? 8'h00 : 8'hFF);
      end
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (irq_out !== 8'h00) begin n_fail++; $display("FAIL midrun_reset: got %h expected 00", irq_out); end
    irq_raw = 8'h00;
    step();
    rst = 1'b1;
    repeat (LAT + 2) step();
  endtask

  task automatic test_edge_ack();
    irq_edge = 8'h04;
    irq_mask = 8'hFF;
    pulse(8'h04, PL);
    repeat (LAT + 2) step();
    n_checks++;
    if (irq_out !== 8'h04) begin n_fail++; $display("FAIL edge_latch: got %h expected 04", irq_out); end
    ack = 1'b1;
    ack_num = 3'd2;
    step();
    ack = 1'b0;
    n_checks++;
    if (irq_out !== 8'h00) begin n_fail++; $display("FAIL edge_ack_clear: got %h expected 00", irq_out); end
    n_checks++;
    if (irq_out !== (m_pend & irq_mask)) begin n_fail++; $display("FAIL edge_ack_model: got %h expected %h", irq_out, m_pend & irq_mask); end
  endtask

  task automatic test_overflow();
    pulse(8'h04, PL);
    repeat (PL + 3) step();
    pulse(8'h04, PL);
    repeat (LAT + 3) step();
    n_checks++;
    if (irq_ovf !== 8'h04) begin n_fail++; $display("FAIL ovf_set: got %h expected 04", irq_ovf); end
    // new rise lands on the same edge as the ack of line 2
    irq_raw = 8'h04;
    repeat (LAT) step();
    ack = 1'b1;
    ack_num = 3'd2;
    step();
    ack = 1'b0;
    irq_raw = 8'h00;
    n_checks++;
    if (irq_out !== 8'h04) begin n_fail++; $display("FAIL set_wins_pending: got %h expected 04", irq_out); end
    n_checks++;
    if (irq_ovf !== 8'h00) begin n_fail++; $display("FAIL set_wins_ovf: got %h expected 00", irq_ovf); end
    repeat (LAT + 2) step();
    ack = 1'b1;
    ack_num = 3'd2;
    step();
    ack = 1'b0;
    n_checks++;
    if (irq_out !== 8'h00) begin n_fail++; $display("FAIL ovf_final_ack: got %h expected 00", irq_out); end
  endtask

  task automatic test_mask();
    irq_edge = 8'h20;
    irq_mask = 8'hDF;
    pulse(8'h20, PL);
    repeat (LAT + 2) step();
    n_checks++;
    if (irq_out !== 8'h00) begin n_fail++; $display("FAIL masked_out: got %h expected 00", irq_out); end
    irq_mask = 8'hFF;
    #1;
    n_checks++;
    if (irq_out !== 8'h20) begin n_fail++; $display("FAIL unmask_immediate: got %h expected 20", irq_out); end
  endtask

  task automatic test_level();
    irq_edge = 8'h00;
    irq_raw = 8'h01;
    repeat (LAT + 1) step();
    for (int c = 0; c < 6; c++) begin
      ack = 1'b1;
      ack_num = 3'd0;
      step();
      n_checks++;
      if (irq_out[0] !== 1'b1) begin n_fail++; $display("FAIL level_ack_ignored c=%0d: got %b expected 1", c, irq_out[0]); end
    end
    ack = 1'b0;
    irq_raw = 8'h00;
    for (int c = 1; c <= LAT + 1; c++) begin
      step();
      n_checks++;
      if (irq_out[0] !== ((c <= LAT) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL level_drop c=%0d: got %b expected %b", c, irq_out[0], (c <= LAT) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic test_filter();
    bit seen;
    int cyc;
    seen = 1'b0;
    irq_edge = 8'h00;
    pulse(8'h08, 2);
    for (int c = 0; c < LAT + 4; c++) begin
      step();
      if (irq_out[3]) seen = 1'b1;
    end
    n_checks++;
    if (seen !== !FILT) begin n_fail++; $display("FAIL short_pulse: got seen=%b expected %b", seen, !FILT); end
    irq_edge = 8'h10;
    repeat (3) step();
    irq_raw = 8'h10;
    cyc = 0;
    while (!irq_out[4] && cyc < 20) begin
      step();
      cyc++;
      if (cyc == 4) irq_raw = 8'h00;
    end
    irq_raw = 8'h00;
    n_checks++;
    if (cyc !== LAT + 1) begin n_fail++; $display("FAIL edge_latency: got %0d edges expected %0d", cyc, LAT + 1); end
    ack = 1'b1;
    ack_num = 3'd4;
    step();
    ack = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) irq_raw[i] = ~irq_raw[i];
      if ($urandom_range(0, 7) == 0) irq_mask = N'($urandom);
      if ($urandom_range(0, 40) == 0) irq_edge = N'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      ack_num = 3'($urandom);
      if (c == 200) begin
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (irq_out !== 8'h00 || irq_ovf !== 8'h00) begin
          n_fail++;
          $display("FAIL rand_reset: got out=%h ovf=%h expected 00/00", irq_out, irq_ovf);
        end
        step();
        rst = 1'b1;
      end
      step();
      n_checks++;
      if (irq_out !== (m_pend & irq_mask)) begin
        n_fail++;
        $display("FAIL rand_out c=%0d: got %h expected %h", c, irq_out, m_pend & irq_mask);
      end
      n_checks++;
      if (irq_ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_ovf c=%0d: got %h expected %h", c, irq_ovf, m_ovf);
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_edge_ack();
    test_overflow();
    test_mask();
    test_level();
    test_filter();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
